buffer_head_controller: RTL and testbench

BUFFER_HEAD_CONTROLLER -- requirements
Module: buffer_head_controller

---
 rtl/buffer_head_controller_if.sv | 26 ++
 rtl/buffer_head_controller.sv | 168 ++++++++++++++++
 tb/tb_buffer_head_controller.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_head_controller_if.sv
// Head-stage and pop-side handshake bundle for buffer_head_controller.
// The slave modport is the controller; master is the surrounding chain/consumer.
interface buffer_head_controller_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  head_addr_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_data_valid;
    logic                  head_ack;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ack;

    modport slave (
        input  head_addr, head_addr_valid, head_data, head_data_valid, out_ack,
        output head_ack, out_addr, out_data, out_valid
    );

    modport master (
        output head_addr, head_addr_valid, head_data, head_data_valid, out_ack,
        input  head_ack, out_addr, out_data, out_valid
    );
endinterface

// File: rtl/buffer_head_controller.sv
// Pops the head line of a ripple chain, tracks allocated lines, flags misuse.
// Optional watchdog on a head stage waiting for data: BUFFER_HEAD_TIMEOUT_EN.
module buffer_head_controller #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clock,
    input  logic                       reset_n,
    buffer_head_controller_if.slave    bus,
    input  logic                       alloc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       timeout
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, PRESENT, SHIFT} state_t;

    if (DEPTH < 2 || DEPTH > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("buffer_head_controller: DEPTH must be 2..255 and TIMEOUT_CYCLES >= 1");
    end

    state_t                 state_r;
    logic                   head_ack_r;
    logic                   out_valid_r;
    logic [ADDR_WIDTH-1:0]  out_addr_r;
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic [OCC_W-1:0]       occ_r;
    logic                   overflow_r;
    logic [OCC_W-1:0]       occ_next_s;
    logic                   ovf_set_s;
    logic                   shift_s;
    logic                   capture_s;

    assign shift_s   = (state_r == SHIFT);
    assign capture_s = bus.head_addr_valid & bus.head_data_valid;
    assign full      = (occ_r == OCC_W'(DEPTH));
    assign empty     = (occ_r == OCC_W'(0));

    // Next occupancy; simultaneous alloc and shift cancel, illegal moves saturate and flag.
    always_comb begin
        occ_next_s = occ_r;
        ovf_set_s  = 1'b0;
        case ({alloc, shift_s})
            2'b10: begin
                if (full) begin
                    ovf_set_s = 1'b1;
                end else begin
                    occ_next_s = occ_r + OCC_W'(1);
                end
            end
            2'b01: begin
                if (empty) begin
                    ovf_set_s = 1'b1;
                end else begin
                    occ_next_s = occ_r - OCC_W'(1);
                end
            end
            default: occ_next_s = occ_r;
        endcase
    end

    // Pop FSM with registered handshake outputs and the occupancy/overflow state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            head_ack_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_addr_r  <= {ADDR_WIDTH{1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
            occ_r       <= {OCC_W{1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            occ_r      <= occ_next_s;
            overflow_r <= overflow_r | ovf_set_s;
            case (state_r)
                IDLE: begin
                    head_ack_r <= 1'b0;
                    if (bus.head_addr_valid) begin
                        state_r <= WAIT_DATA;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_DATA: begin
                    if (capture_s) begin
                        out_addr_r  <= bus.head_addr;
                        out_data_r  <= bus.head_data;
                        out_valid_r <= 1'b1;
                        state_r     <= PRESENT;
                    end else begin
                        state_r <= WAIT_DATA;
                    end
                end
                PRESENT: begin
                    if (bus.out_ack) begin
                        out_valid_r <= 1'b0;
                        head_ack_r  <= 1'b1;
                        state_r     <= SHIFT;
                    end else begin
                        state_r <= PRESENT;
                    end
                end
                SHIFT: begin
                    head_ack_r <= 1'b0;
                    if (occ_next_s != OCC_W'(0)) begin
                        state_r <= WAIT_DATA;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    head_ack_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.head_ack  = head_ack_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_addr  = out_addr_r;
    assign bus.out_data  = out_data_r;
    assign occupancy     = occ_r;
    assign overflow      = overflow_r;

`ifdef BUFFER_HEAD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] watchdog_r;
    logic [WD_W-1:0] wd_next_s;
    logic            timeout_r;

    // Count cycles spent waiting for head data, saturating at the limit.
    always_comb begin
        wd_next_s = {WD_W{1'b0}};
        if (state_r == WAIT_DATA && !capture_s) begin
            if (watchdog_r == WD_W'(TIMEOUT_CYCLES)) begin
                wd_next_s = watchdog_r;
            end else begin
                wd_next_s = watchdog_r + WD_W'(1);
            end
        end else begin
            wd_next_s = {WD_W{1'b0}};
        end
    end

    // Watchdog register and sticky timeout flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            watchdog_r <= {WD_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            watchdog_r <= wd_next_s;
            timeout_r  <= timeout_r | (wd_next_s == WD_W'(TIMEOUT_CYCLES));
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_buffer_head_controller.sv
// Self-checking bench: directed scenarios plus random traffic against an event-level model.
module tb_buffer_head_controller;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TO    = 16;
`ifdef BUFFER_HEAD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       alloc   = 1'b0;
    logic [3:0] occupancy;
    logic       full, empty, overflow, timeout;

    buffer_head_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    buffer_head_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .alloc(alloc),
        .occupancy(occupancy), .full(full), .empty(empty),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    // Model: lines held, sticky flags, and where the head line is in its life.
    int          m_occ;
    bit          m_ovf, m_tout;
    bit          m_armed;   // head tag seen, waiting for its data
    bit          m_valid;   // a captured line is being offered
    bit          m_ack;     // the chain is being shifted this cycle
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int          m_wait;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_ovf = 0; m_tout = 0; m_armed = 0; m_valid = 0; m_ack = 0;
        m_addr = '0; m_data = '0; m_wait = 0;
    endtask

    task automatic model_step();
        bit shifting = m_ack;
        bit take = m_armed && bus.head_addr_valid && bus.head_data_valid;
        if (alloc && !shifting) begin
            if (m_occ == DEPTH) m_ovf = 1'b1; else m_occ++;
        end else if (!alloc && shifting) begin
            if (m_occ == 0) m_ovf = 1'b1; else m_occ--;
        end
        if (m_armed && !take) begin
            m_wait = (m_wait < TO) ? m_wait + 1 : TO;
            if (TO_EN && m_wait == TO) m_tout = 1'b1;
        end else begin
            m_wait = 0;
        end
        if (shifting) begin
            m_ack = 1'b0;
            m_armed = (m_occ > 0);
        end else if (m_valid) begin
            if (bus.out_ack) begin m_valid = 1'b0; m_ack = 1'b1; end
        end else if (take) begin
            m_addr = bus.head_addr; m_data = bus.head_data; m_valid = 1'b1; m_armed = 1'b0;
        end else if (!m_armed && bus.head_addr_valid) begin
            m_armed = 1'b1;
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("head_ack",  bus.head_ack,  m_ack);
            chk("out_valid", bus.out_valid, m_valid);
            chk("out_addr",  bus.out_addr,  m_addr);
            chk("out_data",  bus.out_data,  m_data);
            chk("occupancy", occupancy,     m_occ);
            chk("full",      full,          m_occ == DEPTH);
            chk("empty",     empty,         m_occ == 0);
            chk("overflow",  overflow,      m_ovf);
            chk("timeout",   timeout,       m_tout);
        end
    end

    task automatic idle_inputs();
        alloc = 1'b0;
        bus.head_addr_valid = 1'b0; bus.head_data_valid = 1'b0; bus.out_ack = 1'b0;
        bus.head_addr = '0; bus.head_data = '0;
    endtask

    task automatic cycle();
        @(posedge clock);
        if (!reset_n) model_reset(); else model_step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        model_reset();
        idle_inputs();
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        int pops, shifts, peak, allocs;
        int occ_seq[$];
        bit prev_ack, prev_v;

        idle_inputs();
        model_reset();
        cycle();
        cycle();
        reset_n = 1'b1;
        cmp_on = 1'b1;
        chk("rst_occupancy", occupancy, 4'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);

        // Single pop: tag with alloc, data two cycles later.
        alloc = 1'b1; bus.head_addr_valid = 1'b1; bus.head_addr = 8'h05;
        cycle();
        alloc = 1'b0;
        cycle();
        chk("pop1_not_yet", bus.out_valid, 1'b0);
        bus.head_data_valid = 1'b1; bus.head_data = 32'h0000_CAFE;
        cycle();
        chk("pop1_valid", bus.out_valid, 1'b1);
        chk("pop1_addr", bus.out_addr, 8'h05);
        chk("pop1_data", bus.out_data, 32'h0000_CAFE);
        idle_inputs();
        bus.out_ack = 1'b1;
        cycle();
        chk("pop1_head_ack", bus.head_ack, 1'b1);
        bus.out_ack = 1'b0;
        cycle();
        chk("pop1_ack_gone", bus.head_ack, 1'b0);
        chk("pop1_empty", empty, 1'b1);
        cycle();
        chk("pop1_idle", bus.out_valid, 1'b0);

        // Consumer stalls for 10 cycles while a line is offered.
        alloc = 1'b1; bus.head_addr_valid = 1'b1; bus.head_addr = 8'h11;
        cycle();
        alloc = 1'b0; bus.head_data_valid = 1'b1; bus.head_data = 32'h1234_5678;
        cycle();
        bus.head_addr_valid = 1'b0; bus.head_data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_data", bus.out_data, 32'h1234_5678);
            chk("stall_head_ack", bus.head_ack, 1'b0);
            chk("stall_occ", occupancy, 4'd1);
        end
        bus.out_ack = 1'b1;
        cycle();
        bus.out_ack = 1'b0;
        cycle();
        chk("stall_drained", empty, 1'b1);

        // Fill to DEPTH, alloc during the shift, then one alloc too many.
        do_reset();
        alloc = 1'b1; bus.head_addr_valid = 1'b1; bus.head_data_valid = 1'b1;
        bus.head_addr = 8'h20; bus.head_data = 32'hAAAA_0000;
        for (int i = 0; i < 8; i++) cycle();
        chk("fill_full", full, 1'b1);
        chk("fill_occ", occupancy, 4'd8);
        chk("fill_no_ovf", overflow, 1'b0);
        alloc = 1'b0; bus.out_ack = 1'b1;
        cycle();
        chk("fill_shift", bus.head_ack, 1'b1);
        alloc = 1'b1; bus.out_ack = 1'b0;
        cycle();
        chk("alloc_shift_occ", occupancy, 4'd8);
        chk("alloc_shift_no_ovf", overflow, 1'b0);
        cycle();
        chk("over_alloc_ovf", overflow, 1'b1);
        chk("over_alloc_occ", occupancy, 4'd8);
        idle_inputs();

        // Three allocations, data always present, consumer always ready.
        do_reset();
        pops = 0; shifts = 0; peak = 0; allocs = 0; prev_ack = 0; prev_v = 0;
        alloc = 1'b1; bus.head_addr_valid = 1'b1; bus.head_data_valid = 1'b1; bus.out_ack = 1'b1;
        bus.head_addr = 8'h40; bus.head_data = 32'h0000_1000;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (bus.out_valid && !prev_v) pops++;
            if (prev_ack) occ_seq.push_back(int'(occupancy));
            if (bus.head_ack) shifts++;
            if (int'(occupancy) > peak) peak = int'(occupancy);
            prev_ack = bus.head_ack; prev_v = bus.out_valid;
            allocs++;
            if (allocs >= 3) alloc = 1'b0;
            bus.head_addr = bus.head_addr + 8'd1;
            bus.head_data = bus.head_data + 32'd1;
            if (allocs >= 3 && occupancy == 4'd0) bus.head_addr_valid = 1'b0;
        end
        chk("b2b_pops", pops, 3);
        chk("b2b_shifts", shifts, 3);
        chk("b2b_peak", peak, 3);
        chk("b2b_steps", occ_seq.size(), 3);
        if (occ_seq.size() == 3) begin
            chk("b2b_step1", occ_seq[0], 2);
            chk("b2b_step2", occ_seq[1], 1);
            chk("b2b_step3", occ_seq[2], 0);
        end
        idle_inputs();

        // Reset while a line is offered drops it without a shift.
        do_reset();
        alloc = 1'b1; bus.head_addr_valid = 1'b1; bus.head_addr = 8'h77;
        cycle();
        alloc = 1'b0; bus.head_data_valid = 1'b1; bus.head_data = 32'h0BAD_F00D;
        cycle();
        chk("midrst_pre_valid", bus.out_valid, 1'b1);
        bus.out_ack = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_occ", occupancy, 4'd0);
        chk("midrst_head_ack", bus.head_ack, 1'b0);
        cycle();
        idle_inputs();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("midrst_no_shift", bus.head_ack, 1'b0);
        end

        // Head tag waits TO cycles without data, then data pops normally.
        do_reset();
        alloc = 1'b1; bus.head_addr_valid = 1'b1; bus.head_addr = 8'h33;
        cycle();
        alloc = 1'b0;
        for (int i = 0; i < TO - 1; i++) cycle();
        chk("wd_before_limit", timeout, 1'b0);
        cycle();
        chk("wd_at_limit", timeout, TO_EN);
        bus.head_data_valid = 1'b1; bus.head_data = 32'h0000_BEEF;
        cycle();
        chk("wd_pop_valid", bus.out_valid, 1'b1);
        chk("wd_pop_data", bus.out_data, 32'h0000_BEEF);
        chk("wd_sticky1", timeout, TO_EN);
        idle_inputs();
        bus.out_ack = 1'b1;
        cycle();
        bus.out_ack = 1'b0;
        cycle();
        chk("wd_drained", empty, 1'b1);
        chk("wd_sticky2", timeout, TO_EN);

        // Random traffic, including illegal sequences, against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            alloc               = ($urandom_range(0, 99) < 25);
            bus.head_addr_valid = ($urandom_range(0, 99) < 70);
            bus.head_data_valid = ($urandom_range(0, 99) < 50);
            bus.out_ack         = ($urandom_range(0, 99) < 50);
            bus.head_addr       = AW'($urandom_range(0, 255));
            bus.head_data       = $urandom;
            cycle();
            if (c == 400) do_reset();
        end

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
